du_cmd_ctrl: RTL and testbench
==============================

DU_CMD_CTRL -- requirements
Module: du_cmd_ctrl

Interface
REQ-001 Parameter NB_UART_DATA, default 8, sets the UART command byte width.
REQ-002 Parameter NB_STATE, default 6, sets the one-hot state register width.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_rx_done  input  1  UART Rx FIFO holds at least one byte.
REQ-006 i_rx_data  input  NB_UART_DATA  UART Rx FIFO head byte.
REQ-007 i_loader_done  input  1  program loader finished (1-cycle pulse).
REQ-008 i_regs_tx_done  input  1  register-file transmitter finished (1-cycle pulse).
REQ-009 i_dmem_tx_done  input  1  data-memory transmitter finished (1-cycle pulse).
REQ-010 i_cpu_halt  input  1  CPU retired a halt instruction (level, valid while o_cpu_en=1).
REQ-011 o_rd  output  1  Rx FIFO pop strobe.
REQ-012 o_loader_start  output  1  start pulse to program loader.
REQ-013 o_regs_tx_start  output  1  start pulse to register-file transmitter.
REQ-014 o_dmem_tx_start  output  1  start pulse to data-memory transmitter.
REQ-015 o_cpu_en  output  1  CPU pipeline advance enable.
REQ-016 o_cpu_rst  output  1  CPU reset, held during program load.
REQ-017 o_busy  output  1  high whenever FSM is not in IDLE.
REQ-018 o_halted  output  1  sticky flag: CPU has halted since last load.

Function
REQ-019 FSM states (one-hot): IDLE, LOAD, RUN, STEP, REGS, DMEM; all outputs except o_halted combinational from state, first-cycle flag and inputs.
REQ-020 Command encoding: 0x01 LOAD, 0x02 RUN, 0x03 STEP, 0x04 REGS, 0x05 DMEM.
REQ-021 IDLE: when i_rx_done=1, assert o_rd for that cycle and go to the state selected by i_rx_data.
REQ-022 IDLE: unknown command byte: assert o_rd (byte discarded), remain in IDLE.
REQ-023 o_rd SHALL be 0 in every state other than IDLE; bytes arriving during a command stay in the FIFO.
REQ-024 A first-cycle flag SHALL be set on every transition into a non-IDLE state and cleared after one cycle in that state.
REQ-025 LOAD: o_loader_start=1 on first cycle only; o_cpu_rst=1 every LOAD cycle; on i_loader_done go to IDLE and clear o_halted.
REQ-026 RUN: if o_halted=1 on entry, go to IDLE next cycle with o_cpu_en=0.
REQ-027 RUN, not halted: o_cpu_en=1 every cycle; when i_cpu_halt=1, set o_halted and go to IDLE; o_cpu_en=0 from the following cycle.
REQ-028 STEP: o_cpu_en=1 for exactly one cycle unless o_halted=1 (then 0); return to IDLE next cycle; i_cpu_halt=1 in that cycle sets o_halted.
REQ-029 REGS: o_regs_tx_start=1 on first cycle only; on i_regs_tx_done go to IDLE.
REQ-030 DMEM: o_dmem_tx_start=1 on first cycle only; on i_dmem_tx_done go to IDLE.
REQ-031 Done pulses SHALL be honoured in any cycle of the owning state, including the first; done pulses in other states are ignored.
REQ-032 At most one start output SHALL be high in any cycle; o_cpu_en and o_cpu_rst SHALL never both be high.
REQ-033 o_busy=1 in all non-IDLE states, including the first cycle after a command is popped.
REQ-034 Illegal state encoding SHALL return to IDLE next cycle with all outputs 0.

Reset
REQ-035 i_rst=1 at a clock edge: state=IDLE, first-cycle flag=0, o_halted=0.
REQ-036 While in IDLE after reset, all outputs are 0 until i_rx_done=1.
REQ-037 Reset mid-command (any state) aborts immediately; no further start, enable or pop is issued.

Verification
REQ-038 Byte 0x01, i_loader_done after 10 cycles -> o_rd 1 cycle, o_loader_start 1 cycle, o_cpu_rst 10+ cycles, back to IDLE, o_halted=0.
REQ-039 Byte 0x02, i_cpu_halt at 20th RUN cycle -> o_cpu_en high 20 cycles, o_halted=1, IDLE; repeat 0x02 -> o_cpu_en stays 0.
REQ-040 Three 0x03 bytes back-to-back -> exactly three single-cycle o_cpu_en pulses, each separated by IDLE pop cycle.
REQ-041 Byte 0x05 then 0x04 queued -> o_dmem_tx_start pulse; 0x04 not popped until i_dmem_tx_done; then o_regs_tx_start pulse.
REQ-042 Byte 0xAA -> o_rd 1 cycle, no start/enable output, o_busy stays 0.
REQ-043 i_rst asserted during RUN -> next cycle IDLE, o_cpu_en=0, o_halted=0, o_busy=0.

Source files
------------

// File: rtl/du_cmd_ctrl.sv
// Debug-unit command controller: pops UART command bytes and sequences loader, CPU run/step and dump transmitters.
// Outputs are decoded combinationally from the one-hot state; only the halted flag is a register output.
module du_cmd_ctrl #(
  parameter int NB_UART_DATA = 8,
  parameter int NB_STATE     = 6
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_rx_done,
  input  logic [NB_UART_DATA-1:0] i_rx_data,
  input  logic                    i_loader_done,
  input  logic                    i_regs_tx_done,
  input  logic                    i_dmem_tx_done,
  input  logic                    i_cpu_halt,
  output logic                    o_rd,
  output logic                    o_loader_start,
  output logic                    o_regs_tx_start,
  output logic                    o_dmem_tx_start,
  output logic                    o_cpu_en,
  output logic                    o_cpu_rst,
  output logic                    o_busy,
  output logic                    o_halted
);

  typedef enum logic [NB_STATE-1:0] {
    S_IDLE = NB_STATE'(1),
    S_LOAD = NB_STATE'(2),
    S_RUN  = NB_STATE'(4),
    S_STEP = NB_STATE'(8),
    S_REGS = NB_STATE'(16),
    S_DMEM = NB_STATE'(32)
  } state_t;

  localparam logic [NB_UART_DATA-1:0] CMD_LOAD = NB_UART_DATA'(1);
  localparam logic [NB_UART_DATA-1:0] CMD_RUN  = NB_UART_DATA'(2);
  localparam logic [NB_UART_DATA-1:0] CMD_STEP = NB_UART_DATA'(3);
  localparam logic [NB_UART_DATA-1:0] CMD_REGS = NB_UART_DATA'(4);
  localparam logic [NB_UART_DATA-1:0] CMD_DMEM = NB_UART_DATA'(5);

  state_t r_state;
  logic   r_first;
  logic   r_halted;
  state_t w_cmd_state;

  always_comb begin
    w_cmd_state = S_IDLE;
    case (i_rx_data)
      CMD_LOAD: w_cmd_state = S_LOAD;
      CMD_RUN:  w_cmd_state = S_RUN;
      CMD_STEP: w_cmd_state = S_STEP;
      CMD_REGS: w_cmd_state = S_REGS;
      CMD_DMEM: w_cmd_state = S_DMEM;
      default:  w_cmd_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_first  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_first <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_rx_done) begin
            r_state <= w_cmd_state;
            r_first <= (w_cmd_state != S_IDLE);
          end
        end
        S_LOAD: begin
          if (i_loader_done) begin
            r_state  <= S_IDLE;
            r_halted <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_halted) begin
            r_state <= S_IDLE;
          end else if (i_cpu_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        S_STEP: begin
          r_state <= S_IDLE;
          if (!r_halted && i_cpu_halt) r_halted <= 1'b1;
        end
        S_REGS: if (i_regs_tx_done) r_state <= S_IDLE;
        S_DMEM: if (i_dmem_tx_done) r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          r_first <= 1'b0;
        end
      endcase
    end
  end

  // Reset masks the decode so an aborted command issues nothing in the reset cycle itself.
  always_comb begin
    o_rd            = 1'b0;
    o_loader_start  = 1'b0;
    o_regs_tx_start = 1'b0;
    o_dmem_tx_start = 1'b0;
    o_cpu_en        = 1'b0;
    o_cpu_rst       = 1'b0;
    o_busy          = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_IDLE: o_rd = i_rx_done;
        S_LOAD: begin
          o_loader_start = r_first;
          o_cpu_rst      = 1'b1;
          o_busy         = 1'b1;
        end
        S_RUN, S_STEP: begin
          o_cpu_en = !r_halted;
          o_busy   = 1'b1;
        end
        S_REGS: begin
          o_regs_tx_start = r_first;
          o_busy          = 1'b1;
        end
        S_DMEM: begin
          o_dmem_tx_start = r_first;
          o_busy          = 1'b1;
        end
        default: o_busy = 1'b0;
      endcase
    end
  end

  assign o_halted = r_halted;

endmodule

// File: tb/tb_du_cmd_ctrl.sv
// Scoreboard bench for du_cmd_ctrl: every non-quiet cycle is matched against a queue of expected output records.
module tb_du_cmd_ctrl;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_loader_done = 1'b0;
  logic       i_regs_tx_done = 1'b0;
  logic       i_dmem_tx_done = 1'b0;
  logic       i_cpu_halt = 1'b0;
  logic       o_rd, o_loader_start, o_regs_tx_start, o_dmem_tx_start;
  logic       o_cpu_en, o_cpu_rst, o_busy, o_halted;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       rd_seen = 1'b0;
  logic [7:0] mon_act;

  always #5 clk = ~clk;

  du_cmd_ctrl #(.NB_UART_DATA(8), .NB_STATE(6)) dut (
    .clk             (clk),
    .i_rst           (i_rst),
    .i_rx_done       (i_rx_done),
    .i_rx_data       (i_rx_data),
    .i_loader_done   (i_loader_done),
    .i_regs_tx_done  (i_regs_tx_done),
    .i_dmem_tx_done  (i_dmem_tx_done),
    .i_cpu_halt      (i_cpu_halt),
    .o_rd            (o_rd),
    .o_loader_start  (o_loader_start),
    .o_regs_tx_start (o_regs_tx_start),
    .o_dmem_tx_start (o_dmem_tx_start),
    .o_cpu_en        (o_cpu_en),
    .o_cpu_rst       (o_cpu_rst),
    .o_busy          (o_busy),
    .o_halted        (o_halted)
  );

  // Record layout: {rd, loader_start, regs_start, dmem_start, cpu_en, cpu_rst, busy, halted}
  function automatic logic [7:0] ev(input logic rd, input logic ls, input logic rs, input logic ds,
                                    input logic en, input logic crst, input logic busy, input logic hlt);
    return {rd, ls, rs, ds, en, crst, busy, hlt};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Rx FIFO model: head byte is presented shortly after each rising edge; a pop seen last cycle removes it.
  always @(posedge clk) begin
    #1;
    if (rd_seen && rx_q.size() != 0) void'(rx_q.pop_front());
    i_rx_done = (rx_q.size() != 0);
    i_rx_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  // Monitor: any cycle with a strobe, enable, cpu reset or busy must match the next expected record.
  always @(negedge clk) begin
    if (!i_rst) begin
      mon_act = {o_rd, o_loader_start, o_regs_tx_start, o_dmem_tx_start, o_cpu_en, o_cpu_rst, o_busy, o_halted};
      if (mon_act[7:1] != 7'd0) begin
        if (exp_q.size() == 0) check("unexpected_activity", mon_act, 8'h00);
        else check("trace", mon_act, exp_q.pop_front());
      end
    end
    rd_seen = o_rd && !i_rst;
  end

  task automatic wait_neg(input int sel, input string name);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      case (sel)
        0: hit = o_loader_start;
        1: hit = o_cpu_en;
        default: hit = o_dmem_tx_start;
      endcase
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout, got 0 expected 1", name);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 400 && (exp_q.size() != 0 || rx_q.size() != 0); k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(name, 8'(exp_q.size() + rx_q.size()), 8'h00);
  endtask

  task automatic do_load(input logic h);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, h));
    exp_q.push_back(ev(0, 1, 0, 0, 0, 1, 1, h));
    for (int k = 0; k < 9; k++) exp_q.push_back(ev(0, 0, 0, 0, 0, 1, 1, h));
    rx_q.push_back(8'h01);
    wait_neg(0, "load_start_wait");
    repeat (9) @(posedge clk);
    #1 i_loader_done = 1'b1;
    @(posedge clk);
    #1 i_loader_done = 1'b0;
    drain("load_drain");
    check("load_halted_clear", {7'd0, o_halted}, 8'h00);
  endtask

  initial begin
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {o_rd, o_loader_start, o_regs_tx_start, o_dmem_tx_start,
                            o_cpu_en, o_cpu_rst, o_busy, o_halted}, 8'h00);

    // Unknown byte: popped and discarded, never busy.
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0));
    rx_q.push_back(8'hAA);
    drain("unknown_drain");

    do_load(1'b0);

    // Three queued steps: pop, one enable cycle, pop, ...
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 1, 0));
      rx_q.push_back(8'h03);
    end
    drain("step3_drain");

    // Run halted on its 20th cycle.
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 20; k++) exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 1, 0));
    rx_q.push_back(8'h02);
    wait_neg(1, "run_en_wait");
    repeat (19) @(posedge clk);
    #1 i_cpu_halt = 1'b1;
    @(posedge clk);
    #1 i_cpu_halt = 1'b0;
    drain("run_drain");
    check("run_halted_set", {7'd0, o_halted}, 8'h01);

    // Run and step while halted: one busy cycle, no enable.
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 1));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 1, 1));
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 1));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 1, 1));
    rx_q.push_back(8'h02);
    rx_q.push_back(8'h03);
    drain("halted_cmds_drain");

    do_load(1'b1);

    // Step that retires a halt sets the sticky flag.
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 1, 0));
    i_cpu_halt = 1'b1;
    rx_q.push_back(8'h03);
    drain("step_halt_drain");
    i_cpu_halt = 1'b0;
    check("step_halted_set", {7'd0, o_halted}, 8'h01);

    @(posedge clk);
    #1 i_rst = 1'b1;
    @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("reset_clears_halted", {7'd0, o_halted}, 8'h00);

    // DMEM dump then queued REGS dump; a regs done during DMEM is ignored, regs done on first cycle honoured.
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(0, 0, 0, 1, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++) exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 1, 0));
    rx_q.push_back(8'h05);
    rx_q.push_back(8'h04);
    wait_neg(2, "dmem_start_wait");
    @(posedge clk);
    #1 i_regs_tx_done = 1'b1;
    @(posedge clk);
    #1 i_regs_tx_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 i_dmem_tx_done = 1'b1;
    @(posedge clk);
    #1 i_dmem_tx_done = 1'b0;
    @(posedge clk);
    #1 i_regs_tx_done = 1'b1;
    @(posedge clk);
    #1 i_regs_tx_done = 1'b0;
    drain("dump_drain");

    // Reset in the 6th RUN cycle aborts at once.
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 1, 0));
    rx_q.push_back(8'h02);
    wait_neg(1, "run2_en_wait");
    repeat (5) @(posedge clk);
    #1 i_rst = 1'b1;
    @(negedge clk);
    check("reset_cycle_cpu_en", {7'd0, o_cpu_en}, 8'h00);
    @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("after_reset_run", {o_rd, o_loader_start, o_regs_tx_start, o_dmem_tx_start,
                              o_cpu_en, o_cpu_rst, o_busy, o_halted}, 8'h00);
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
